// File: rtl/ap_ctrl_txn_profiler.sv
// ap_ctrl_txn_profiler
// Watches one ap_ctrl_hs handshake and records one entry per transaction:
// id, latency, start interval and iteration count. Entries go into a small
// FIFO that the CSV sampler drains over a valid/ready stream.
module ap_ctrl_txn_profiler #(
    parameter int CW    = 32,
    parameter int IDW   = 16,
    parameter int DEPTH = 4,
    parameter int DROPW = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             iter_pulse,
    input  logic             finish,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [IDW-1:0]   rec_id,
    output logic [CW-1:0]    rec_latency,
    output logic [CW-1:0]    rec_interval,
    output logic [CW-1:0]    rec_iters,
    output logic             rec_partial,
    output logic [DROPW-1:0] drop_cnt,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, WAIT_CONT, HALT} state_t;

    typedef struct packed {
        logic           partial;
        logic [CW-1:0]  iters;
        logic [CW-1:0]  interval;
        logic [CW-1:0]  latency;
        logic [IDW-1:0] id;
    } rec_t;

    state_t          state, state_next;
    logic [CW-1:0]   cyc;
    logic [CW-1:0]   ts;
    logic [CW-1:0]   cur_interval;
    logic [CW-1:0]   cur_iters;
    logic [CW-1:0]   lat_frozen;
    logic            first;
    logic [IDW-1:0]  id;

    logic [CW-1:0]   lat_now;
    logic [CW-1:0]   iters_plus;
    logic [CW-1:0]   start_int;
    logic [CW-1:0]   start_iters;

    logic            push;
    rec_t            push_rec;
    logic            start_cap;
    logic            freeze;
    logic [CW-1:0]   freeze_val;
    logic            iter_inc;

    rec_t            mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            fifo_empty, fifo_full, pop, do_write, do_drop;

    // ap_ready is diagnostic only and never affects timing or state
    logic unused_ap_ready;
    assign unused_ap_ready = ap_ready;

    assign lat_now     = cyc - ts + CW'(1);
    assign iters_plus  = (cur_iters == {CW{1'b1}}) ? cur_iters : cur_iters + CW'(1);
    assign start_int   = first ? '0 : cyc - ts;
    assign start_iters = iter_pulse ? CW'(1) : '0;

    // Next-state logic and the record to push when a transaction closes
    always_comb begin
        state_next       = state;
        push             = 1'b0;
        push_rec.partial = 1'b0;
        push_rec.iters   = cur_iters;
        push_rec.interval = cur_interval;
        push_rec.latency = lat_now;
        push_rec.id      = id;
        start_cap        = 1'b0;
        freeze           = 1'b0;
        freeze_val       = lat_now;
        iter_inc         = 1'b0;
        case (state)
            IDLE: begin
                if (finish) begin
                    state_next = HALT;
                end else if (ap_start) begin
                    start_cap = 1'b1;
                    if (ap_done && ap_continue) begin
                        push              = 1'b1;
                        push_rec.latency  = CW'(1);
                        push_rec.interval = start_int;
                        push_rec.iters    = start_iters;
                    end else if (ap_done) begin
                        freeze     = 1'b1;
                        freeze_val = CW'(1);
                        state_next = WAIT_CONT;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                push_rec.iters = iter_pulse ? iters_plus : cur_iters;
                iter_inc       = iter_pulse;
                if (finish) begin
                    push             = 1'b1;
                    push_rec.partial = 1'b1;
                    state_next       = HALT;
                end else if (ap_done && ap_continue) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end else if (ap_done) begin
                    freeze     = 1'b1;
                    state_next = WAIT_CONT;
                end
            end
            WAIT_CONT: begin
                push_rec.latency = lat_frozen;
                if (finish) begin
                    push             = 1'b1;
                    push_rec.partial = 1'b1;
                    state_next       = HALT;
                end else if (ap_continue) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = HALT;
            end
        endcase
    end

    // State register, cycle counter and per-transaction bookkeeping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cyc          <= '0;
            ts           <= '0;
            cur_interval <= '0;
            cur_iters    <= '0;
            lat_frozen   <= '0;
            first        <= 1'b1;
            id           <= '0;
        end else begin
            state <= state_next;
            cyc   <= cyc + CW'(1);
            if (start_cap) begin
                ts           <= cyc;
                cur_interval <= start_int;
                cur_iters    <= start_iters;
                first        <= 1'b0;
            end else if (iter_inc) begin
                cur_iters <= iters_plus;
            end
            if (freeze) begin
                lat_frozen <= freeze_val;
            end
            if (push) begin
                id <= id + IDW'(1);
            end
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && rec_ready;
    assign do_write   = push && (!fifo_full || pop);
    assign do_drop    = push && fifo_full && !pop;

    // Record FIFO; a push into a full FIFO survives only if the head pops that cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_write) begin
                mem[wr_ptr[AW-1:0]] <= push_rec;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_drop && (drop_cnt != {DROPW{1'b1}})) begin
                drop_cnt <= drop_cnt + DROPW'(1);
            end
        end
    end

    assign rec_valid    = !fifo_empty;
    assign rec_id       = mem[rd_ptr[AW-1:0]].id;
    assign rec_latency  = mem[rd_ptr[AW-1:0]].latency;
    assign rec_interval = mem[rd_ptr[AW-1:0]].interval;
    assign rec_iters    = mem[rd_ptr[AW-1:0]].iters;
    assign rec_partial  = mem[rd_ptr[AW-1:0]].partial;
    assign busy         = (state == BUSY) || (state == WAIT_CONT);

endmodule

// File: tb/tb_ap_ctrl_txn_profiler.sv
// tb_ap_ctrl_txn_profiler
// Directed bench for the transaction profiler with hand-computed expectations.
module tb_ap_ctrl_txn_profiler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_ready = 1'b0;
    logic        ap_done = 1'b0;
    logic        ap_continue = 1'b1;
    logic        iter_pulse = 1'b0;
    logic        finish = 1'b0;
    logic        rec_valid;
    logic        rec_ready = 1'b0;
    logic [15:0] rec_id;
    logic [31:0] rec_latency;
    logic [31:0] rec_interval;
    logic [31:0] rec_iters;
    logic        rec_partial;
    logic [7:0]  drop_cnt;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int expIds [4] = '{1, 2, 3, 6};

    ap_ctrl_txn_profiler #(.CW(32), .IDW(16), .DEPTH(4), .DROPW(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .iter_pulse   (iter_pulse),
        .finish       (finish),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_id       (rec_id),
        .rec_latency  (rec_latency),
        .rec_interval (rec_interval),
        .rec_iters    (rec_iters),
        .rec_partial  (rec_partial),
        .drop_cnt     (drop_cnt),
        .busy         (busy)
    );

    // Free-running clock, period 10
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic s, input logic d, input logic c,
                                 input logic ip, input logic f, input logic r);
        ap_start    = s;
        ap_done     = d;
        ap_continue = c;
        iter_pulse  = ip;
        finish      = f;
        rec_ready   = r;
        ap_ready    = d;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 1, 0, 0, 0);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    // Directed sequence covering the main handshake scenarios
    initial begin
        // Reset state
        doReset();
        checkOutput("rst_valid", rec_valid, 0);
        checkOutput("rst_drop", drop_cnt, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_id", rec_id, 0);
        checkOutput("rst_lat", rec_latency, 0);

        // 1: start with pulse, one more pulse, done four cycles after start
        $display("[TB] scenario 1: basic transaction");
        applyStimulus(1, 0, 1, 1, 0, 0);
        step(1);
        checkOutput("t1_busy", busy, 1);
        applyStimulus(0, 0, 1, 1, 0, 0);
        step(1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        step(2);
        applyStimulus(0, 1, 1, 0, 0, 0);
        step(1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t1_valid", rec_valid, 1);
        checkOutput("t1_id", rec_id, 0);
        checkOutput("t1_lat", rec_latency, 5);
        checkOutput("t1_int", rec_interval, 0);
        checkOutput("t1_iters", rec_iters, 2);
        checkOutput("t1_partial", rec_partial, 0);
        checkOutput("t1_busy_end", busy, 0);
        applyStimulus(0, 0, 1, 0, 0, 1);
        step(1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t1_drained", rec_valid, 0);

        // 2: two single-cycle transactions three cycles apart
        $display("[TB] scenario 2: start and done in the same cycle");
        doReset();
        applyStimulus(1, 1, 1, 0, 0, 0);
        step(1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t2_valid", rec_valid, 1);
        step(2);
        applyStimulus(1, 1, 1, 0, 0, 0);
        step(1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t2_id0", rec_id, 0);
        checkOutput("t2_lat0", rec_latency, 1);
        checkOutput("t2_int0", rec_interval, 0);
        applyStimulus(0, 0, 1, 0, 0, 1);
        step(1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t2_id1", rec_id, 1);
        checkOutput("t2_lat1", rec_latency, 1);
        checkOutput("t2_int1", rec_interval, 3);
        applyStimulus(0, 0, 1, 0, 0, 1);
        step(1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t2_empty", rec_valid, 0);

        // 3: done without continue, held off four cycles, then back-to-back start
        $display("[TB] scenario 3: wait for continue");
        doReset();
        applyStimulus(1, 0, 1, 0, 0, 0);
        step(1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        step(2);
        applyStimulus(0, 1, 0, 0, 0, 0);
        step(1);
        applyStimulus(1, 0, 0, 1, 0, 0);
        step(1);
        checkOutput("t3_busy_wait", busy, 1);
        checkOutput("t3_no_rec", rec_valid, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        step(2);
        checkOutput("t3_still_none", rec_valid, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        step(1);
        checkOutput("t3_valid", rec_valid, 1);
        checkOutput("t3_lat", rec_latency, 4);
        checkOutput("t3_iters", rec_iters, 0);
        checkOutput("t3_idle", busy, 0);
        step(1);
        checkOutput("t3_restart", busy, 1);
        applyStimulus(0, 1, 1, 0, 0, 0);
        step(1);
        applyStimulus(0, 0, 1, 0, 0, 1);
        step(1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t3_id1", rec_id, 1);
        checkOutput("t3_lat1", rec_latency, 2);
        checkOutput("t3_int1", rec_interval, 8);

        // 4: six transactions with the consumer stalled, then push-with-pop on full
        $display("[TB] scenario 4: overflow and drain");
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, 1, 0, 0, 0);
            step(1);
            applyStimulus(0, 0, 1, 0, 0, 0);
            step(1);
        end
        checkOutput("t4_drop", drop_cnt, 2);
        checkOutput("t4_head", rec_id, 0);
        applyStimulus(1, 1, 1, 0, 0, 1);
        step(1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t4_drop_keep", drop_cnt, 2);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t4_drain_id", rec_id, expIds[i]);
            applyStimulus(0, 0, 1, 0, 0, 1);
            step(1);
            applyStimulus(0, 0, 1, 0, 0, 0);
        end
        checkOutput("t4_empty", rec_valid, 0);

        // 5: finish while busy after seven cycles with three pulses
        $display("[TB] scenario 5: finish mid-transaction");
        doReset();
        applyStimulus(1, 0, 1, 0, 0, 0);
        step(1);
        applyStimulus(0, 0, 1, 1, 0, 0);
        step(3);
        applyStimulus(0, 0, 1, 0, 0, 0);
        step(2);
        applyStimulus(0, 0, 1, 0, 1, 0);
        step(1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t5_valid", rec_valid, 1);
        checkOutput("t5_partial", rec_partial, 1);
        checkOutput("t5_lat", rec_latency, 7);
        checkOutput("t5_iters", rec_iters, 3);
        checkOutput("t5_busy", busy, 0);
        applyStimulus(1, 1, 1, 0, 0, 0);
        step(2);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t5_halt_busy", busy, 0);
        applyStimulus(0, 0, 1, 0, 0, 1);
        step(1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t5_halt_norec", rec_valid, 0);

        // 6: reset while busy with two records queued
        $display("[TB] scenario 6: reset mid-transaction");
        doReset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 1, 0, 0, 0);
            step(1);
            applyStimulus(0, 0, 1, 0, 0, 0);
            step(1);
        end
        applyStimulus(1, 0, 1, 0, 0, 0);
        step(1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t6_pre_busy", busy, 1);
        checkOutput("t6_pre_valid", rec_valid, 1);
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_valid", rec_valid, 0);
        checkOutput("t6_rst_drop", drop_cnt, 0);
        checkOutput("t6_rst_busy", busy, 0);
        step(1);
        reset = 1'b0;
        applyStimulus(1, 1, 1, 0, 0, 0);
        step(1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t6_valid", rec_valid, 1);
        checkOutput("t6_id", rec_id, 0);
        checkOutput("t6_int", rec_interval, 0);
        checkOutput("t6_lat", rec_latency, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
